// File: rtl/mux_sched_pkg.sv
// Shared types and helpers for the round-robin mux scheduler.
package mux_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } sched_state_t;

    // Width needed to hold a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_if.sv
// Connection between the scheduler (master) and the shared 2:1 mux (slave).
interface mux_if #(
    parameter int DATA_WITH = 12
);
    logic [DATA_WITH-1:0] a;
    logic [DATA_WITH-1:0] b;
    logic                 sel;
    logic [DATA_WITH-1:0] y;

    modport master (output a, output b, output sel, input y);
    modport slave  (input a, input b, input sel, output y);
endinterface

// File: rtl/mux2to1_wrapper.sv
// Combinational 2:1 mux on a mux_if slave port: sel=0 -> a, sel=1 -> b.
module mux2to1_wrapper (
    mux_if.slave s
);
    assign s.y = s.sel ? s.b : s.a;
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer, wrapping.
module rr_arbiter
    import mux_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_valid
);
    logic [ID_W:0]      w_sum;
    logic [ID_W-1:0]    w_cand;
    logic               w_hit;
    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_idx;

    // Walk candidates ptr, ptr+1, ... modulo NUM_REQ and keep the first requester seen.
    always_comb begin
        w_sum  = '0;
        w_cand = '0;
        w_hit  = 1'b0;
        w_gnt  = '0;
        w_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, i_ptr} + (ID_W + 1)'(i);
            if (w_sum >= (ID_W + 1)'(NUM_REQ)) begin
                w_sum = w_sum - (ID_W + 1)'(NUM_REQ);
            end
            w_cand = w_sum[ID_W-1:0];
            if (i_en && !w_hit && i_req[w_cand]) begin
                w_hit         = 1'b1;
                w_idx         = w_cand;
                w_gnt[w_cand] = 1'b1;
            end
        end
    end

    assign o_gnt   = w_gnt;
    assign o_idx   = w_idx;
    assign o_valid = w_hit;
endmodule

// File: rtl/mux_rr_scheduler.sv
// Shares one combinational mux among NUM_REQ requesters, one transaction in flight.
// Output handshake: a result transfers on a cycle where o_y_valid and i_y_ready are
// both high; o_y/o_y_id hold steady while o_y_valid is high and i_y_ready is low.
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int DATA_WITH = 12,
    localparam int ID_W      = id_width(NUM_REQ)
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [NUM_REQ*DATA_WITH-1:0]   i_a,
    input  logic [NUM_REQ*DATA_WITH-1:0]   i_b,
    input  logic [NUM_REQ-1:0]             i_sel,
    output logic [NUM_REQ-1:0]             o_gnt,
    output logic [DATA_WITH-1:0]           o_y,
    output logic [ID_W-1:0]                o_y_id,
    output logic                           o_y_valid,
    input  logic                           i_y_ready,
    output logic                           o_busy,
    mux_if.master                          master_if,
    output sched_state_t                   o_dbg_state
);
    sched_state_t         r_state;
    logic [ID_W-1:0]      r_ptr;
    logic [DATA_WITH-1:0] r_a;
    logic [DATA_WITH-1:0] r_b;
    logic                 r_sel;
    logic [ID_W-1:0]      r_id;
    logic [DATA_WITH-1:0] r_y;
    logic [ID_W-1:0]      r_y_id;

    logic                 w_arb_en;
    logic [NUM_REQ-1:0]   w_gnt;
    logic [ID_W-1:0]      w_idx;
    logic                 w_gnt_valid;

    // Arbitrate from IDLE, or from RESP on the cycle the result is consumed.
    // Gated by reset so no grant strobe leaks out while reset is asserted.
    assign w_arb_en = i_rst_n &&
                      ((r_state == IDLE) || ((r_state == RESP) && i_y_ready));

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .i_en    (w_arb_en),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_valid (w_gnt_valid)
    );

    // Operand capture on grant plus the IDLE -> ISSUE -> RESP sequencing.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sel   <= 1'b0;
            r_id    <= '0;
            r_y     <= '0;
            r_y_id  <= '0;
        end else begin
            if (w_gnt_valid) begin
                r_a   <= i_a[w_idx*DATA_WITH +: DATA_WITH];
                r_b   <= i_b[w_idx*DATA_WITH +: DATA_WITH];
                r_sel <= i_sel[w_idx];
                r_id  <= w_idx;
                r_ptr <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    r_state <= w_gnt_valid ? ISSUE : IDLE;
                end
                ISSUE: begin
                    r_y     <= master_if.y;
                    r_y_id  <= r_id;
                    r_state <= RESP;
                end
                RESP: begin
                    if (i_y_ready) begin
                        r_state <= w_gnt_valid ? ISSUE : IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // The mux always sees the operand registers; only the ISSUE-cycle result is used.
    assign master_if.a   = r_a;
    assign master_if.b   = r_b;
    assign master_if.sel = r_sel;

    assign o_gnt       = w_gnt;
    assign o_y         = r_y;
    assign o_y_id      = r_y_id;
    assign o_y_valid   = (r_state == RESP);
    assign o_busy      = (r_state != IDLE);
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed bench for mux_rr_scheduler: a 12-bit 4-requester instance and a 4-bit one.
module tb_mux_rr_scheduler;
    import mux_sched_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (DATA_WITH=12) ----------------
    logic [3:0]  req;
    logic [11:0] a_arr [4];
    logic [11:0] b_arr [4];
    logic [3:0]  sel;
    logic [47:0] pa;
    logic [47:0] pb;
    logic        y_ready;
    logic [3:0]  gnt;
    logic [11:0] y;
    logic [1:0]  y_id;
    logic        y_valid;
    logic        busy;
    sched_state_t dbg_state;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            pa[k*12 +: 12] = a_arr[k];
            pb[k*12 +: 12] = b_arr[k];
        end
    end

    mux_if #(.DATA_WITH(12)) u_if ();
    mux2to1_wrapper u_mux (.s(u_if));

    mux_rr_scheduler #(.NUM_REQ(4), .DATA_WITH(12)) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_a         (pa),
        .i_b         (pb),
        .i_sel       (sel),
        .o_gnt       (gnt),
        .o_y         (y),
        .o_y_id      (y_id),
        .o_y_valid   (y_valid),
        .i_y_ready   (y_ready),
        .o_busy      (busy),
        .master_if   (u_if),
        .o_dbg_state (dbg_state)
    );

    // ---------------- narrow DUT (DATA_WITH=4) ----------------
    logic [3:0]  w_req;
    logic [3:0]  w_a_arr [4];
    logic [3:0]  w_b_arr [4];
    logic [3:0]  w_sel;
    logic [15:0] w_pa;
    logic [15:0] w_pb;
    logic [3:0]  w_gnt;
    logic [3:0]  w_y;
    logic [1:0]  w_y_id;
    logic        w_y_valid;
    logic        w_busy;
    sched_state_t w_dbg_state;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_pa[k*4 +: 4] = w_a_arr[k];
            w_pb[k*4 +: 4] = w_b_arr[k];
        end
    end

    mux_if #(.DATA_WITH(4)) u_if_w ();
    mux2to1_wrapper u_mux_w (.s(u_if_w));

    mux_rr_scheduler #(.NUM_REQ(4), .DATA_WITH(4)) u_dut_w (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (w_req),
        .i_a         (w_pa),
        .i_b         (w_pb),
        .i_sel       (w_sel),
        .o_gnt       (w_gnt),
        .o_y         (w_y),
        .o_y_id      (w_y_id),
        .o_y_valid   (w_y_valid),
        .i_y_ready   (y_ready),
        .o_busy      (w_busy),
        .master_if   (u_if_w),
        .o_dbg_state (w_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    // Expected results of the rotation test, in grant order 0,1,2,3
    // (sel=1010: k0 A, k1 B, k2 A, k3 B).
    logic [11:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance to just after the next active edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    // Safety net: the directed sequence is far shorter than this.
    initial begin
        #100000;
        $display("FAIL timeout: got 0x0 expected 0x1");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int ki;
        logic [11:0] ey;
        rst_n   = 1'b0;
        req     = 4'b0001;
        sel     = 4'b0000;
        y_ready = 1'b1;
        w_req   = 4'b0001;
        w_sel   = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            a_arr[k]   = '0;
            b_arr[k]   = '0;
            w_a_arr[k] = '0;
            w_b_arr[k] = '0;
        end
        #1;

        // Reset state: everything zero even with requests present.
        check("rst_gnt",    32'(gnt),       32'h0);
        check("rst_w_gnt",  32'(w_gnt),     32'h0);
        check("rst_valid",  32'(y_valid),   32'h0);
        check("rst_busy",   32'(busy),      32'h0);
        check("rst_y",      32'(y),         32'h0);
        check("rst_id",     32'(y_id),      32'h0);
        check("rst_mux_a",  32'(u_if.a),    32'h0);
        check("rst_state",  32'(dbg_state), 32'(IDLE));
        step();
        step();
        rst_n = 1'b1;
        req   = 4'b0000;
        w_req = 4'b0000;
        #1;

        // Single request: B operand selected, result valid two cycles after grant.
        a_arr[0] = 12'hABC;
        b_arr[0] = 12'h123;
        sel      = 4'b0001;
        req      = 4'b0001;
        #1;
        check("t1_gnt", 32'(gnt), 32'h1);
        step();
        req = 4'b0000;
        #1;
        check("t1_issue_gnt",   32'(gnt),       32'h0);
        check("t1_issue_busy",  32'(busy),      32'h1);
        check("t1_issue_valid", 32'(y_valid),   32'h0);
        check("t1_issue_state", 32'(dbg_state), 32'(ISSUE));
        check("t1_mux_a",       32'(u_if.a),    32'hABC);
        step();
        #1;
        check("t1_valid", 32'(y_valid), 32'h1);
        check("t1_y",     32'(y),       32'h123);
        check("t1_id",    32'(y_id),    32'h0);
        step();
        #1;
        check("t1_idle_valid", 32'(y_valid), 32'h0);
        check("t1_idle_busy",  32'(busy),    32'h0);

        // Rotation with all four requesting, fresh pointer.
        do_reset();
        a_arr[0] = 12'h111; a_arr[1] = 12'h222; a_arr[2] = 12'h333; a_arr[3] = 12'h444;
        b_arr[0] = 12'h555; b_arr[1] = 12'h666; b_arr[2] = 12'h777; b_arr[3] = 12'h888;
        sel = 4'b1010;
        exp_q = {12'h111, 12'h666, 12'h333, 12'h888, 12'h111};
        req = 4'b1111;
        #1;
        for (int i = 0; i < 5; i++) begin
            ki = i % 4;
            check("rot_gnt", 32'(gnt), 32'(4'b0001 << ki));
            step();
            if (i == 4) req = 4'b0000;
            #1;
            check("rot_issue_gnt", 32'(gnt), 32'h0);
            step();
            #1;
            ey = exp_q.pop_front();
            check("rot_valid", 32'(y_valid), 32'h1);
            check("rot_y",     32'(y),       32'(ey));
            check("rot_id",    32'(y_id),    32'(ki));
        end
        check("rot_end_gnt", 32'(gnt), 32'h0);
        step();
        #1;

        // Backpressure: pointer is 1, requester 2 granted, result held 5 cycles.
        req     = 4'b0100;
        y_ready = 1'b0;
        #1;
        check("bp_gnt", 32'(gnt), 32'h4);
        step();
        req = 4'b1000;
        #1;
        check("bp_issue_gnt", 32'(gnt), 32'h0);
        step();
        #1;
        for (int j = 0; j < 5; j++) begin
            check("bp_valid", 32'(y_valid), 32'h1);
            check("bp_y",     32'(y),       32'h333);
            check("bp_id",    32'(y_id),    32'h2);
            check("bp_gnt0",  32'(gnt),     32'h0);
            step();
            #1;
        end
        y_ready = 1'b1;
        #1;
        check("bp_hs_valid", 32'(y_valid), 32'h1);
        check("bp_hs_gnt",   32'(gnt),     32'h8);
        step();
        req = 4'b0000;
        #1;
        check("bp_next_state", 32'(dbg_state), 32'(ISSUE));
        step();
        #1;
        check("bp_next_y",  32'(y),    32'h888);
        check("bp_next_id", 32'(y_id), 32'h3);
        step();
        #1;

        // Pointer wrap: pointer is 0.
        req = 4'b1000;
        #1;
        check("wrap_gnt3", 32'(gnt), 32'h8);
        step();
        req = 4'b1001;
        #1;
        step();
        #1;
        check("wrap_gnt0", 32'(gnt),  32'h1);
        check("wrap_y3",   32'(y),    32'h888);
        check("wrap_id3",  32'(y_id), 32'h3);
        step();
        req = 4'b1000;
        #1;
        step();
        #1;
        check("wrap_gnt3b", 32'(gnt),  32'h8);
        check("wrap_y0",    32'(y),    32'h111);
        check("wrap_id0",   32'(y_id), 32'h0);
        step();
        #1;
        step();
        #1;
        check("sole_gnt", 32'(gnt), 32'h8);
        step();
        req = 4'b0000;
        #1;
        step();
        #1;
        check("sole_id", 32'(y_id), 32'h3);
        step();
        #1;

        // Reset in ISSUE: pointer would be 2 without reset.
        req = 4'b0010;
        #1;
        check("rmid_gnt", 32'(gnt), 32'h2);
        step();
        req = 4'b0100;
        #1;
        check("rmid_state", 32'(dbg_state), 32'(ISSUE));
        rst_n = 1'b0;
        #1;
        check("rmid_gnt0",  32'(gnt),       32'h0);
        check("rmid_busy",  32'(busy),      32'h0);
        check("rmid_valid", 32'(y_valid),   32'h0);
        check("rmid_y",     32'(y),         32'h0);
        check("rmid_id",    32'(y_id),      32'h0);
        check("rmid_mux_a", 32'(u_if.a),    32'h0);
        check("rmid_idle",  32'(dbg_state), 32'(IDLE));
        step();
        step();
        rst_n = 1'b1;
        req   = 4'b0101;
        #1;
        check("post_rst_ptr0", 32'(gnt), 32'h1);
        req = 4'b0100;
        #1;
        check("post_rst_gnt2", 32'(gnt), 32'h4);
        step();
        req = 4'b0000;
        #1;
        step();
        #1;
        check("post_rst_y",  32'(y),    32'h333);
        check("post_rst_id", 32'(y_id), 32'h2);
        step();
        #1;

        // Narrow instance: sel=0 picks A, then sel=1 on requester 2 picks B.
        w_a_arr[0] = 4'h5;
        w_b_arr[0] = 4'hA;
        w_sel      = 4'b0000;
        w_req      = 4'b0001;
        #1;
        check("w_gnt0", 32'(w_gnt), 32'h1);
        step();
        w_req = 4'b0000;
        #1;
        step();
        #1;
        check("w_y0",     32'(w_y),       32'h5);
        check("w_id0",    32'(w_y_id),    32'h0);
        check("w_valid0", 32'(w_y_valid), 32'h1);
        w_a_arr[2] = 4'h3;
        w_b_arr[2] = 4'hC;
        w_sel      = 4'b0100;
        w_req      = 4'b0100;
        #1;
        check("w_gnt2", 32'(w_gnt), 32'h4);
        step();
        w_req = 4'b0000;
        #1;
        step();
        #1;
        check("w_y2",  32'(w_y),    32'hC);
        check("w_id2", 32'(w_y_id), 32'h2);
        step();
        #1;

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
